// File: rtl/morse_encoder.sv
// Morse transmit encoder: one ASCII character per handshake, keyed out
// on key_out with a programmable unit length.
module morse_encoder #(
    parameter int UNIT_CYCLES = 4,
    parameter int LGAP_UNITS  = 3,
    parameter int WGAP_UNITS  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    output logic       key_out,
    output logic       busy,
    output logic       err
);

    localparam int CW = $clog2(UNIT_CYCLES + 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(UNIT_CYCLES - 1);
    localparam logic [2:0] LGAP_LEN = 3'(LGAP_UNITS);
    localparam logic [2:0] WGAP_LEN = 3'(WGAP_UNITS);

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        ESPACE,
        LGAP,
        WGAP
    } state_t;

    state_t state, state_n;

    logic [CW-1:0] cyc, cyc_n;
    logic [2:0]    unit, unit_n;
    logic [1:0]    idx, idx_n;
    logic [2:0]    len_q, len_n;
    logic [3:0]    pat_q, pat_n;
    logic          err_n;

    logic [7:0]    upper;
    logic [6:0]    entry;
    logic [2:0]    phase_len;
    logic          unit_tick;
    logic          phase_end;

    // Returns {length, elements}; elements left-aligned, 1 = dash.
    // A length of zero marks a code that is not a letter.
    function automatic logic [6:0] lut(input logic [7:0] c);
        case (c)
            8'h41:   lut = {3'd2, 4'b0100};
            8'h42:   lut = {3'd4, 4'b1000};
            8'h43:   lut = {3'd4, 4'b1010};
            8'h44:   lut = {3'd3, 4'b1000};
            8'h45:   lut = {3'd1, 4'b0000};
            8'h46:   lut = {3'd4, 4'b0010};
            8'h47:   lut = {3'd3, 4'b1100};
            8'h48:   lut = {3'd4, 4'b0000};
            8'h49:   lut = {3'd2, 4'b0000};
            8'h4A:   lut = {3'd4, 4'b0111};
            8'h4B:   lut = {3'd3, 4'b1010};
            8'h4C:   lut = {3'd4, 4'b0100};
            8'h4D:   lut = {3'd2, 4'b1100};
            8'h4E:   lut = {3'd2, 4'b1000};
            8'h4F:   lut = {3'd3, 4'b1110};
            8'h50:   lut = {3'd4, 4'b0110};
            8'h51:   lut = {3'd4, 4'b1101};
            8'h52:   lut = {3'd3, 4'b0100};
            8'h53:   lut = {3'd3, 4'b0000};
            8'h54:   lut = {3'd1, 4'b1000};
            8'h55:   lut = {3'd3, 4'b0010};
            8'h56:   lut = {3'd4, 4'b0001};
            8'h57:   lut = {3'd3, 4'b0110};
            8'h58:   lut = {3'd4, 4'b1001};
            8'h59:   lut = {3'd4, 4'b1011};
            8'h5A:   lut = {3'd4, 4'b1100};
            default: lut = 7'd0;
        endcase
    endfunction

    assign char_ready = (state == IDLE);

    always_comb begin
        upper = char_in;
        if (char_in >= 8'h61 && char_in <= 8'h7A) begin
            upper = char_in - 8'h20;
        end
    end

    assign entry = lut(upper);

    always_comb begin
        phase_len = 3'd1;
        unique case (state)
            MARK:    phase_len = pat_q[~idx] ? 3'd3 : 3'd1;
            LGAP:    phase_len = LGAP_LEN;
            WGAP:    phase_len = WGAP_LEN;
            default: phase_len = 3'd1;
        endcase
    end

    assign unit_tick = (cyc == CYC_LAST);
    assign phase_end = unit_tick && (unit == phase_len - 3'd1);

    always_comb begin
        state_n = state;
        cyc_n   = cyc;
        unit_n  = unit;
        idx_n   = idx;
        len_n   = len_q;
        pat_n   = pat_q;
        err_n   = 1'b0;

        if (state != IDLE) begin
            if (phase_end) begin
                cyc_n  = '0;
                unit_n = '0;
            end else if (unit_tick) begin
                cyc_n  = '0;
                unit_n = unit + 3'd1;
            end else begin
                cyc_n = cyc + 1'b1;
            end
        end

        unique case (state)
            IDLE: begin
                if (char_valid) begin
                    if (entry[6:4] != 3'd0) begin
                        state_n = MARK;
                        len_n   = entry[6:4];
                        pat_n   = entry[3:0];
                        idx_n   = '0;
                    end else if (char_in == 8'h20) begin
                        state_n = WGAP;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            MARK: begin
                if (phase_end) begin
                    if ({1'b0, idx} == len_q - 3'd1) begin
                        state_n = LGAP;
                    end else begin
                        state_n = ESPACE;
                    end
                end
            end
            ESPACE: begin
                if (phase_end) begin
                    state_n = MARK;
                    idx_n   = idx + 2'd1;
                end
            end
            LGAP, WGAP: begin
                if (phase_end) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cyc     <= '0;
            unit    <= '0;
            idx     <= '0;
            len_q   <= '0;
            pat_q   <= '0;
            key_out <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            cyc     <= cyc_n;
            unit    <= unit_n;
            idx     <= idx_n;
            len_q   <= len_n;
            pat_q   <= pat_n;
            key_out <= (state_n == MARK);
            busy    <= (state_n != IDLE);
            err     <= err_n;
        end
    end

endmodule

// File: tb/tb_morse_encoder.sv
// Directed bench for morse_encoder with a two-cycle unit.
module tb_morse_encoder;

    logic       clk;
    logic       reset;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;
    logic       key_out;
    logic       busy;
    logic       err;

    int checks = 0;
    int errors = 0;

    morse_encoder #(
        .UNIT_CYCLES(2),
        .LGAP_UNITS(3),
        .WGAP_UNITS(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .char_in(char_in),
        .char_valid(char_valid),
        .char_ready(char_ready),
        .key_out(key_out),
        .busy(busy),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0b want %0b", tag, obs, exp);
        end
    endtask

    // Idle cycle: verify ready, then present a character for the next edge.
    task automatic start(input string tag, input logic [7:0] c);
        @(negedge clk);
        check({tag, "_rdy"}, char_ready, 1'b1);
        check({tag, "_idle"}, busy, 1'b0);
        char_valid = 1'b1;
        char_in    = c;
    endtask

    // Alternating mark/space run lengths in cycles, mark first.
    task automatic play(input string tag, input int segs[6],
                        input logic nv, input logic [7:0] nc);
        bit first = 1'b1;
        for (int s = 0; s < 6; s++) begin
            for (int k = 0; k < segs[s]; k++) begin
                @(negedge clk);
                if (first) begin
                    char_valid = nv;
                    char_in    = nc;
                    first      = 1'b0;
                end
                check({tag, "_key"}, key_out, (s % 2) == 0);
                check({tag, "_busy"}, busy, 1'b1);
                check({tag, "_nrdy"}, char_ready, 1'b0);
                check({tag, "_err"}, err, 1'b0);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        char_valid = 1'b0;
        char_in    = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_key", key_out, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_rdy", char_ready, 1'b1);

        start("E", 8'h45);
        play("E", '{2, 6, 0, 0, 0, 0}, 1'b0, 8'h00);

        start("A", 8'h41);
        play("A", '{2, 2, 6, 6, 0, 0}, 1'b0, 8'h00);

        start("O", 8'h4F);
        play("O", '{6, 2, 6, 2, 6, 6}, 1'b1, 8'h53);
        @(negedge clk);
        check("OS_rdy", char_ready, 1'b1);
        check("OS_idle", busy, 1'b0);
        play("S", '{2, 2, 2, 2, 2, 6}, 1'b0, 8'h00);

        start("g", 8'h67);
        play("g", '{6, 2, 6, 2, 2, 6}, 1'b0, 8'h00);
        start("sp", 8'h20);
        play("sp", '{0, 8, 0, 0, 0, 0}, 1'b0, 8'h00);

        start("hash", 8'h23);
        @(negedge clk);
        char_valid = 1'b0;
        check("hash_err", err, 1'b1);
        check("hash_key", key_out, 1'b0);
        check("hash_busy", busy, 1'b0);
        check("hash_rdy", char_ready, 1'b1);
        @(negedge clk);
        check("hash_err_end", err, 1'b0);
        check("hash_rdy2", char_ready, 1'b1);

        start("M", 8'h4D);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            char_valid = 1'b0;
            check("M_key", key_out, 1'b1);
            check("M_busy", busy, 1'b1);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_key", key_out, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_rdy", char_ready, 1'b1);

        start("T", 8'h54);
        play("T", '{6, 6, 0, 0, 0, 0}, 1'b0, 8'h00);
        @(negedge clk);
        check("T_done_rdy", char_ready, 1'b1);
        check("T_done_key", key_out, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/morse_encoder.md
Name: morse_encoder

Overview:
- Transmit-side companion to the team's Morse decoder.
- Accepts one ASCII character per valid/ready handshake and keys it out as a timed on/off Morse signal on `key_out`, driven from `clk`.
- Timing is set by a programmable unit length; the output feeds a tone gate or LED driver.
- Covers letters A–Z (upper or lower case) and space; all other characters are flagged and dropped.

Parameters:
- `UNIT_CYCLES`, default 4: clk cycles per Morse time unit; legal range ≥1.
- `LGAP_UNITS`, default 3: off units appended after every letter's last element.
- `WGAP_UNITS`, default 4: off units for a space character; with the preceding letter gap this gives 7 units total.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `char_in`  in  8  ASCII character; sampled on handshake.
- `char_valid`  in  1  producer has a character on `char_in`.
- `char_ready`  out  1  encoder can accept a character this cycle.
- `key_out`  out  1  1 = carrier on (mark), 0 = off; registered.
- `busy`  out  1  1 while a character (letter or space) is being keyed; registered.
- `err`  out  1  one-cycle pulse when an unsupported character is accepted; registered.

Behaviour:
- Reset values:
  - State is IDLE; `key_out`=0, `busy`=0, `err`=0; all counters 0.
  - `char_ready`=1 after the reset edge.
  - Reset asserted mid-character aborts it: `key_out`=0 the cycle after the reset edge, and the in-flight character is discarded.
- Handshake:
  - `char_ready` = (state==IDLE), combinational from state.
  - A transfer occurs at a rising edge where `char_valid` && `char_ready`. `char_in` is captured only then.
  - `char_valid` while not ready is ignored; the producer holds it.
- Lookup table:
  - Lower case 0x61–0x7A maps to upper case.
  - Each letter is stored as a length L (1–4) plus L element bits, first element first; 0 = dot, 1 = dash.
  - Contents follow the international Morse table, e.g. E=".", T="-", A=".-", N="-.", I="..", M="--", S="...", U="..-", G="--.", O="---", Q="--.-".
- States:
  - IDLE: `key_out`=0, `busy`=0.
    - Valid letter accepted → MARK (element 0), `busy`=1.
    - Space (0x20) accepted → WGAP, `busy`=1.
    - Any other code accepted → stay in IDLE, `err`=1 for exactly the next cycle, `char_ready` stays 1.
  - MARK: `key_out`=1 for 1 unit (dot) or 3 units (dash).
    - At the end: if more elements remain → ESPACE; otherwise → LGAP.
  - ESPACE: `key_out`=0 for 1 unit, then → MARK on the next element.
  - LGAP: `key_out`=0 for `LGAP_UNITS` units, then → IDLE.
  - WGAP: `key_out`=0 for `WGAP_UNITS` units, then → IDLE.
- Timing:
  - One unit = `UNIT_CYCLES` cycles.
  - `key_out` first rises in the cycle after the accepting edge; there are no dead cycles between phases.
  - `char_ready` returns high in the cycle after the final gap cycle. A back-to-back character can be accepted on that edge, with no extra idle cycle.
- Counters:
  - Cycle counter width `$clog2(UNIT_CYCLES+1)`; it wraps to 0 at `UNIT_CYCLES-1` and advances the unit counter.
  - Unit counter is 3 bits (maximum 7 units).
  - Element index is 2 bits, counted against L.
- `busy` equals (state != IDLE), registered to align with `key_out`.
- `err` never asserts together with `busy`.

Test Plan (`UNIT_CYCLES`=2, `LGAP_UNITS`=3, `WGAP_UNITS`=4):
- Reset, then send 'E' (0x45) → `key_out` 1 for 2 cycles, then 0 for 6. `busy` is high for 8 cycles; `char_ready` is 0 for those 8 cycles and 1 on cycle 9.
- Send 'A' (0x41) → `key_out` pattern 1×2, 0×2, 1×6, 0×6 (16 cycles). `err`=0 throughout.
- Send "O" then "S" back-to-back with `char_valid` held high →
  - 'O': 1×6, 0×2, 1×6, 0×2, 1×6, 0×6.
  - 'S' accepted on the first ready edge: 1×2, 0×2, 1×2, 0×2, 1×2, 0×6.
  - No extra idle cycle between the two characters.
- Send 'g' (0x67), then 0x20 → 'g' keyed as G (1×6, 0×2, 1×6, 0×2, 1×2, 0×6), then the space gives `key_out`=0 and `busy`=1 for 8 cycles.
- Send '#' (0x23) → `err`=1 for exactly 1 cycle, `key_out`/`busy` stay 0, and `char_ready` stays 1.
- Send 'M' and assert `reset` on the 3rd cycle of the first dash → `key_out`=0 the next cycle, `busy`=0, `char_ready`=1. A subsequent 'T' keys 1×6, 0×6 normally.
